// File: rtl/crc4_pkg.sv
// Shared definitions for the CRC4 (x^4 + x + 1) frame-check datapath:
// generator polynomial, FSM state encoding and the single-bit remainder update.
package crc4_pkg;

   localparam int CRC_W = 4;
   localparam logic [CRC_W:0] CRC_POLY = 5'b10011;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Shift one message bit into the remainder and reduce modulo the generator.
   function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] rem,
                                                  input logic din);
      logic [CRC_W:0] t;
      t = {rem, din};
      if (t[CRC_W]) begin
         t = t ^ CRC_POLY;
      end
      return t[CRC_W-1:0];
   endfunction

endpackage

// File: rtl/crc4_serial_engine.sv
// Serial CRC4 remainder register: one bit per enabled cycle, MSB first.
// Kept free of any framing logic so other CRC4 paths can reuse it.
module crc4_serial_engine
   import crc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       shift_en,
   input  logic       din,
   output logic [3:0] rem
);

   logic [CRC_W-1:0] rem_d;
   logic [CRC_W-1:0] rem_q;

   always_comb begin
      rem_d = rem_q;
      if (clr) begin
         rem_d = '0;
      end else if (shift_en) begin
         rem_d = crc4_step(rem_q, din);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem = rem_q;

endmodule

// File: rtl/crc4_check_sched.sv
// Round-robin scheduler sharing one serial CRC4 check engine between NREQ
// frame sources; reports a per-frame verdict and keeps a saturating error count.
module crc4_check_sched
   import crc4_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int FRAME_W = 19
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*FRAME_W-1:0]   frame,
   output logic [NREQ-1:0]           grant,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(NREQ)-1:0]   done_id,
   output logic                      crc_error,
   output logic [15:0]               err_cnt,
   input  logic                      clr_cnt
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = $clog2(FRAME_W);
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   state_t             state_d, state_q;
   logic [FRAME_W-1:0] sreg_d, sreg_q;
   logic [CNT_W-1:0]   bitcnt_d, bitcnt_q;
   logic [ID_W-1:0]    id_d, id_q;
   logic [ID_W-1:0]    last_d, last_q;
   logic               done_d, done_q;
   logic               crc_error_d, crc_error_q;
   logic [ID_W-1:0]    done_id_d, done_id_q;
   logic [15:0]        err_cnt_d, err_cnt_q;

   logic               win_found;
   logic [ID_W-1:0]    win_idx;
   logic               start;
   logic [3:0]         rem;
   int                 idx;

   // Rotating priority: the requester after the previous winner is searched first.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_q) + k) % NREQ;
         if (!win_found && req[ID_W'(idx)]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   assign start = (state_q == IDLE) && en && win_found;
   assign grant = start ? (ONE_HOT0 << win_idx) : '0;
   assign busy  = (state_q != IDLE);

   crc4_serial_engine u_engine (
      .clk      (clk),
      .rst      (rst),
      .clr      (start),
      .shift_en (state_q == SHIFT),
      .din      (sreg_q[FRAME_W-1]),
      .rem      (rem)
   );

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      bitcnt_d    = bitcnt_q;
      id_d        = id_q;
      last_d      = last_q;
      done_d      = 1'b0;
      crc_error_d = crc_error_q;
      done_id_d   = done_id_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SHIFT;
               sreg_d   = frame[int'(win_idx)*FRAME_W +: FRAME_W];
               id_d     = win_idx;
               last_d   = win_idx;
               bitcnt_d = '0;
            end
         end
         SHIFT: begin
            sreg_d   = sreg_q << 1;
            bitcnt_d = bitcnt_q + 1'b1;
            // The verdict includes the bit entering the engine on this same edge.
            if (bitcnt_q == CNT_W'(FRAME_W - 1)) begin
               state_d     = DONE;
               done_d      = 1'b1;
               crc_error_d = (crc4_step(rem, sreg_q[FRAME_W-1]) != '0);
               done_id_d   = id_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (done_q && crc_error_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         bitcnt_q    <= '0;
         id_q        <= '0;
         last_q      <= ID_W'(NREQ - 1);
         done_q      <= 1'b0;
         crc_error_q <= 1'b0;
         done_id_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         bitcnt_q    <= bitcnt_d;
         id_q        <= id_d;
         last_q      <= last_d;
         done_q      <= done_d;
         crc_error_q <= crc_error_d;
         done_id_q   <= done_id_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign done      = done_q;
   assign crc_error = crc_error_q;
   assign done_id   = done_id_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc4_check_sched.sv
// Self-checking bench for crc4_check_sched: directed scenarios plus random
// frames, checked against a polynomial-division and round-robin reference model.
module tb_crc4_check_sched;

   localparam int NREQ    = 4;
   localparam int FRAME_W = 19;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    en;
   logic [NREQ-1:0]         req;
   logic [NREQ*FRAME_W-1:0] frameBus;
   logic [NREQ-1:0]         grant;
   logic                    busy;
   logic                    done;
   logic [1:0]              done_id;
   logic                    crc_error;
   logic [15:0]             err_cnt;
   logic                    clr_cnt;

   logic [FRAME_W-1:0] fr [NREQ];

   int    errors = 0;
   int    checks = 0;
   int    lastM;
   int    expId;
   logic  expErr;
   logic [15:0] errM;

   crc4_check_sched #(.NREQ(NREQ), .FRAME_W(FRAME_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .frame     (frameBus),
      .grant     (grant),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .crc_error (crc_error),
      .err_cnt   (err_cnt),
      .clr_cnt   (clr_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      frameBus = '0;
      for (int i = 0; i < NREQ; i++) begin
         frameBus[i*FRAME_W +: FRAME_W] = fr[i];
      end
   end

   // Remainder of the whole frame polynomial divided by x^4 + x + 1.
   function automatic logic [3:0] crcRem(input logic [FRAME_W-1:0] f);
      logic [31:0] r;
      r = 32'(f);
      for (int b = FRAME_W - 1; b >= 4; b--) begin
         if (r[b]) r = r ^ (32'h13 << (b - 4));
      end
      return r[3:0];
   endfunction

   function automatic logic [FRAME_W-1:0] makeFrame(input logic bad);
      logic [FRAME_W-1:0] f;
      f = FRAME_W'($urandom) << 4;
      f[3:0] = crcRem(f);
      if (bad) f = f ^ (FRAME_W'(1) << $urandom_range(0, FRAME_W - 1));
      return f;
   endfunction

   function automatic int pickWinner(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle after inputs settle; checks grant and records the expected verdict.
   task automatic expectGrant(input string tag);
      int w;
      logic [NREQ-1:0] expG;
      w = en ? pickWinner(req, lastM) : -1;
      expG = (w >= 0) ? (NREQ'(1) << w) : '0;
      checkOutput(tag, 32'(grant), 32'(expG));
      if (w >= 0) begin
         lastM  = w;
         expId  = w;
         expErr = (crcRem(fr[w]) != 4'd0);
      end
   endtask

   task automatic applyStimulus(input logic dropReq, input logic [NREQ-1:0] nextReq,
                                input int enLowAt, input logic clrAtDone);
      int  n;
      bit  seen;
      seen = 1'b0;
      for (n = 1; n <= FRAME_W + 5; n++) begin
         @(negedge clk);
         if (n == 1 && dropReq) req = '0;
         if (n == enLowAt) en = 1'b0;
         #1;
         if (n == 1) checkOutput("busy_shift", 32'(busy), 32'd1);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("done_latency", seen ? n : 0, FRAME_W + 1);
      checkOutput("done_id", 32'(done_id), 32'(expId));
      checkOutput("crc_error", 32'(crc_error), 32'(expErr));
      if (clrAtDone) begin
         clr_cnt = 1'b1;
         errM = 16'd0;
      end else if (expErr && errM != 16'hFFFF) begin
         errM = errM + 16'd1;
      end
      @(negedge clk);
      clr_cnt = 1'b0;
      req = nextReq;
      #1;
      checkOutput("done_pulse_end", 32'(done), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("err_cnt", 32'(err_cnt), 32'(errM));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = '0; clr_cnt = 1'b0;
      for (int i = 0; i < NREQ; i++) fr[i] = '0;
      lastM = NREQ - 1; errM = 16'd0; expId = 0; expErr = 1'b0;

      // Reset values.
      @(negedge clk); #1;
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_done_id", 32'(done_id), 32'd0);
      checkOutput("rst_crc_error", 32'(crc_error), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk); rst = 1'b0; en = 1'b1;

      // Valid codeword from requester 0.
      @(negedge clk);
      fr[0] = 19'h00013; req = 4'b0001; #1;
      expectGrant("grant_valid0");
      applyStimulus(1'b1, '0, 0, 1'b0);

      // Single-bit error from requester 2.
      @(negedge clk);
      fr[2] = 19'h00012; req = 4'b0100; #1;
      expectGrant("grant_err2");
      applyStimulus(1'b1, '0, 0, 1'b0);

      // All requesters held: rotation and back-to-back spacing.
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) fr[i] = makeFrame(1'($urandom_range(0, 1)));
      req = 4'b1111; #1;
      for (int k = 0; k < 5; k++) begin
         expectGrant("grant_rr");
         applyStimulus(1'b0, (k == 4) ? 4'b0000 : 4'b1111, 0, 1'b0);
      end

      // Enable gating of new grants; disabling mid-frame does not disturb it.
      @(negedge clk);
      en = 1'b0; req = 4'b0010; fr[1] = makeFrame(1'b1);
      for (int k = 0; k < 3; k++) begin
         #1; expectGrant("grant_en_low");
         @(negedge clk);
      end
      en = 1'b1; #1;
      expectGrant("grant_en_high");
      applyStimulus(1'b1, '0, 5, 1'b0);
      en = 1'b1;

      // Reset in the middle of a frame.
      @(negedge clk);
      fr[0] = makeFrame(1'b1); req = 4'b0001; #1;
      expectGrant("grant_pre_abort");
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         req = '0;
      end
      rst = 1'b1; #1;
      lastM = NREQ - 1; errM = 16'd0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("abort_crc_error", 32'(crc_error), 32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (n == 1) rst = 1'b0;
         #1;
         checkOutput("abort_no_done", 32'(done), 32'd0);
      end
      fr[0] = makeFrame(1'b0); fr[3] = makeFrame(1'b1); req = 4'b1001; #1;
      expectGrant("grant_after_abort0");
      applyStimulus(1'b0, 4'b1001, 0, 1'b0);
      expectGrant("grant_after_abort1");
      applyStimulus(1'b1, '0, 0, 1'b0);

      // Saturation of the error counter.
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.err_cnt_q;
      errM = 16'hFFFE; #1;
      checkOutput("sat_preload", 32'(err_cnt), 32'h0000FFFE);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         fr[0] = makeFrame(1'b1); req = 4'b0001; #1;
         expectGrant("grant_sat");
         applyStimulus(1'b1, '0, 0, 1'b0);
      end

      // Clear wins over a simultaneous increment.
      @(negedge clk);
      fr[2] = makeFrame(1'b1); req = 4'b0100; #1;
      expectGrant("grant_clr");
      applyStimulus(1'b1, '0, 0, 1'b1);

      // Random request patterns and frames.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) fr[i] = makeFrame(1'($urandom_range(0, 1)));
         req = NREQ'($urandom_range(1, 15)); #1;
         expectGrant("grant_rnd");
         applyStimulus(1'b1, '0, 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crc4_check_sched.md
# crc4_check_sched

Round-robin scheduler that shares one serial CRC4 check engine (G(x) = x^4 + x + 1) between NREQ frame sources. It grants one requester at a time and latches that requester's parallel frame. The frame is shifted MSB-first through the engine, and a per-frame verdict is returned together with the requester id. The block sits between the frame receivers and the status/interrupt logic, and keeps a saturating error count.

## Interface
- NREQ, 4: number of requesters, 2..8
- FRAME_W, 19: frame width in bits, message plus the 4-bit CRC field at the LSBs, 5..32
- clk  in  1: single clock, rising edge
- rst  in  1: asynchronous, active-high reset
- en  in  1: when low, no new grant is issued; a frame already in progress completes
- req  in  NREQ: per-requester request level
- frame  in  NREQ*FRAME_W: requester i's frame is at bits [i*FRAME_W +: FRAME_W]
- grant  out  NREQ: one-hot, high for exactly one cycle when a frame is accepted
- busy  out  1: high in SHIFT and DONE
- done  out  1: one-cycle pulse when a verdict is valid
- done_id  out  $clog2(NREQ): index of the requester whose frame finished; valid with done
- crc_error  out  1: 1 when the final remainder is nonzero; valid with done
- err_cnt  out  16: saturating count of frames with crc_error=1
- clr_cnt  in  1: synchronous clear of err_cnt

## Operation
- FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE → SHIFT when en=1 and req≠0. In that cycle:
  - grant is driven combinationally, one-hot, to the winner.
  - At the clock edge: the winner's frame goes into the shift register, the winner index goes into id_q and last_q, the remainder clears to 0, and bitcnt clears to 0.
- Round-robin arbitration: search starts at last_q+1 mod NREQ. last_q resets to NREQ-1, so req[0] has first priority after reset.
- SHIFT: one bit per cycle, MSB first.
  - Engine update: t = {rem[3:0], bit}; rem_next = t[4] ? (t ^ 5'b10011) : t, keeping bits [3:0].
  - bitcnt increments each cycle; after FRAME_W bits, SHIFT → DONE.
- DONE lasts exactly one cycle.
  - done=1, crc_error=(rem≠0), done_id=id_q.
  - err_cnt increments if crc_error=1 and err_cnt<16'hFFFF.
  - Next state is IDLE.
- clr_cnt=1 sets err_cnt to 0. This has priority over a simultaneous increment.
- Requester rules:
  - Hold req and frame stable until grant.
  - Drop req by the cycle after grant, otherwise the frame is re-checked.
  - req is sampled only in IDLE.
- en=0 during SHIFT or DONE has no effect on the current frame.

## Timing
- Reset values:
  - grant=0, busy=0, done=0, done_id=0, crc_error=0, err_cnt=0.
  - Internal: state=IDLE, last_q=NREQ-1, rem=0, bitcnt=0.
- Latency: if grant is high in cycle T, done is high in cycle T+FRAME_W+1.
- Throughput: the earliest next grant is at T+FRAME_W+2, so a back-to-back frame takes one frame per FRAME_W+2 cycles.
- Output registration:
  - done, crc_error, done_id and err_cnt are registered.
  - grant is combinational from state, en, req and last_q.
  - crc_error and done_id hold their last values between done pulses.
- If rst is asserted mid-frame, all registers reset immediately. No done pulse is produced for the aborted frame, and the requester must re-request.
- All requesters active with en=1 continuously: grant order is 0,1,2,3,0,…
- err_cnt at 16'hFFFF together with an error holds at 16'hFFFF.

## Structure
- Package crc4_pkg holds:
  - localparam CRC_POLY = 5'b10011 and CRC_W = 4.
  - typedef for the FSM state enum {IDLE, SHIFT, DONE}.
- Sub-module crc4_serial_engine: inputs clk, rst, clr, shift_en, din; output rem[3:0]. It holds the remainder register and update rule only, so it is reusable by other CRC4 paths.
- crc4_check_sched holds the arbiter, frame shift register, bitcnt, FSM, result registers and err_cnt.

## Test plan
- Reset, then req=4'b0001 with frame0=19'h00013 (valid codeword) → grant=4'b0001 in T; done, done_id=0, crc_error=0 at T+20; err_cnt=0.
- req=4'b0100 with frame2=19'h00012 (single-bit error) → done at T+20 with done_id=2, crc_error=1; err_cnt=1.
- req=4'b1111 held, en=1, all frames 19'h0 → grants 0,1,2,3,0 spaced 21 cycles apart; every crc_error=0.
- en=0 with req=4'b0010 → no grant. en=1 → grant next cycle. en=0 mid-SHIFT → done still at T+20.
- rst pulsed at T+10 during a frame → all outputs 0, no done pulse. Then req=4'b1000 → it wins; round-robin restarts from last_q=3.
- err_cnt preloaded near 16'hFFFF, then error frames → holds at 16'hFFFF. clr_cnt in the same cycle as done with crc_error=1 → err_cnt=0.
